// File: rtl/nand_seq_if.sv
// -----------------------------------------------------------------------------
// nand_seq_if
// Bundles the harness-facing and cell-facing signals of the NAND cell sequencer.
//   start     harness -> sequencer   run request (level, sampled in IDLE)
//   gate_y    cell    -> sequencer   NAND cell output y
//   gate_a/b  sequencer -> cell      NAND cell inputs a / b
//   busy      sequencer -> harness   run in progress
//   done      sequencer -> harness   one-cycle run-complete pulse
//   pass      sequencer -> harness   last completed run had no mismatches
//   result    sequencer -> harness   sampled y per vector
//   err_mask  sequencer -> harness   per-vector mismatch flags
//   fail_cnt  sequencer -> harness   saturating count of failed runs
// master = harness/cell side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface nand_seq_if;
   logic       start;
   logic       gate_a;
   logic       gate_b;
   logic       gate_y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] result;
   logic [3:0] err_mask;
   logic [7:0] fail_cnt;

   modport master (
      output start,
      output gate_y,
      input  gate_a,
      input  gate_b,
      input  busy,
      input  done,
      input  pass,
      input  result,
      input  err_mask,
      input  fail_cnt
   );

   modport slave (
      input  start,
      input  gate_y,
      output gate_a,
      output gate_b,
      output busy,
      output done,
      output pass,
      output result,
      output err_mask,
      output fail_cnt
   );
endinterface

// File: rtl/nand_seq_ctrl.sv
// -----------------------------------------------------------------------------
// nand_seq_ctrl
// Self-checking sequencer for a 2-input NAND cell. On start it walks the cell
// inputs through vectors 00,01,10,11, holds each for SETTLE_CYCLES cycles,
// samples y on the following cycle and compares it with the NAND truth table.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears everything, incl. fail_cnt)
//   bus    nand_seq_if.slave: start/gate_y in; gate_a/gate_b, busy, done,
//          pass, result[3:0], err_mask[3:0], fail_cnt[7:0] out (all registered)
// Parameter:
//   SETTLE_CYCLES  hold cycles per vector before the sample cycle, 1..15
// -----------------------------------------------------------------------------
module nand_seq_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   nand_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   // Expected NAND output for vector index idx (a = idx[1], b = idx[0]).
   function automatic logic nand_expect(input logic [1:0] idx);
      return ~(idx[1] & idx[0]);
   endfunction

   state_t     state_r,      state_nxt_s;
   logic [1:0] idx_r,        idx_nxt_s;
   logic [3:0] cnt_r,        cnt_nxt_s;
   logic       gate_a_r,     gate_a_nxt_s;
   logic       gate_b_r,     gate_b_nxt_s;
   logic       busy_r,       busy_nxt_s;
   logic       done_r,       done_nxt_s;
   logic       pass_r,       pass_nxt_s;
   logic [3:0] result_r,     result_nxt_s;
   logic [3:0] err_mask_r,   err_mask_nxt_s;
   logic [7:0] fail_cnt_r,   fail_cnt_nxt_s;
   logic       mismatch_s;

   // Case-inequality so an X or Z from the cell is reported as a mismatch.
   assign mismatch_s = (bus.gate_y !== nand_expect(idx_r));

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         idx_r      <= 2'd0;
         cnt_r      <= 4'd0;
         gate_a_r   <= 1'b0;
         gate_b_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
         result_r   <= 4'd0;
         err_mask_r <= 4'd0;
         fail_cnt_r <= 8'd0;
      end else begin
         state_r    <= state_nxt_s;
         idx_r      <= idx_nxt_s;
         cnt_r      <= cnt_nxt_s;
         gate_a_r   <= gate_a_nxt_s;
         gate_b_r   <= gate_b_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         pass_r     <= pass_nxt_s;
         result_r   <= result_nxt_s;
         err_mask_r <= err_mask_nxt_s;
         fail_cnt_r <= fail_cnt_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt_s = ST_SETTLE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            // <= rather than == so a corrupted zero count cannot wrap to 15.
            if (cnt_r <= 4'd1) begin
               state_nxt_s = ST_SAMPLE;
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end
         ST_SAMPLE: begin
            if (idx_r == 2'd3) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs and datapath.
   always_comb begin
      idx_nxt_s      = idx_r;
      cnt_nxt_s      = cnt_r;
      gate_a_nxt_s   = gate_a_r;
      gate_b_nxt_s   = gate_b_r;
      pass_nxt_s     = pass_r;
      result_nxt_s   = result_r;
      err_mask_nxt_s = err_mask_r;
      fail_cnt_nxt_s = fail_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               idx_nxt_s      = 2'd0;
               cnt_nxt_s      = SETTLE_LOAD;
               gate_a_nxt_s   = 1'b0;
               gate_b_nxt_s   = 1'b0;
               pass_nxt_s     = 1'b0;
               result_nxt_s   = 4'd0;
               err_mask_nxt_s = 4'd0;
            end else begin
               idx_nxt_s      = idx_r;
            end
         end
         ST_SETTLE: begin
            cnt_nxt_s = cnt_r - 4'd1;
         end
         ST_SAMPLE: begin
            result_nxt_s[idx_r]   = bus.gate_y;
            err_mask_nxt_s[idx_r] = err_mask_r[idx_r] | mismatch_s;
            if (idx_r == 2'd3) begin
               // pass/fail_cnt see the final vector's update made on this edge.
               pass_nxt_s = (err_mask_nxt_s == 4'd0);
               if (err_mask_nxt_s != 4'd0 && fail_cnt_r != 8'hFF) begin
                  fail_cnt_nxt_s = fail_cnt_r + 8'd1;
               end else begin
                  fail_cnt_nxt_s = fail_cnt_r;
               end
            end else begin
               idx_nxt_s                    = idx_r + 2'd1;
               cnt_nxt_s                    = SETTLE_LOAD;
               {gate_a_nxt_s, gate_b_nxt_s} = idx_r + 2'd1;
            end
         end
         ST_DONE: begin
            idx_nxt_s = idx_r;
         end
         default: begin
            idx_nxt_s = 2'd0;
            cnt_nxt_s = 4'd0;
         end
      endcase
      busy_nxt_s = (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_SAMPLE);
      done_nxt_s = (state_nxt_s == ST_DONE);
   end

   assign bus.gate_a   = gate_a_r;
   assign bus.gate_b   = gate_b_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.pass     = pass_r;
   assign bus.result   = result_r;
   assign bus.err_mask = err_mask_r;
   assign bus.fail_cnt = fail_cnt_r;

endmodule
